// File: rtl/vmul_job_sequencer_if.sv
// Requester/datapath-control bundle for vmul_job_sequencer.
// master = requesting side, slave = sequencer.
interface vmul_job_sequencer_if #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 3
);
    localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] req;
    logic               abort;
    logic [NUM_REQ-1:0] grant;
    logic [OWN_W-1:0]   owner;
    logic               busy;
    logic               acc_clr;
    logic               issue_valid;
    logic [IDX_W-1:0]   row_idx;
    logic [NUM_REQ-1:0] done;

    modport master (
        output req, abort,
        input  grant, owner, busy, acc_clr, issue_valid, row_idx, done
    );

    modport slave (
        input  req, abort,
        output grant, owner, busy, acc_clr, issue_valid, row_idx, done
    );
endinterface

// File: rtl/vmul_job_sequencer.sv
// Round-robin job sequencer for the 8x8 pipelined vector multiplier: per job a grant/acc_clr
// pulse, ROWS issue strobes, PIPE_LAT drain cycles, then a done pulse to the owner.
module vmul_job_sequencer #(
    parameter int NUM_REQ  = 2,
    parameter int ROWS     = 8,
    parameter int PIPE_LAT = 3,
    parameter int IDX_W    = 3
) (
    input  logic                clk,
    input  logic                rstn,
    vmul_job_sequencer_if.slave bus
);
    localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [IDX_W-1:0] LAST_ROW   = IDX_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;
    logic [OWN_W-1:0]   owner_q;
    logic [OWN_W-1:0]   rr_q;
    logic               busy_q;
    logic               acc_clr_q;
    logic               issue_valid_q;
    logic [IDX_W-1:0]   row_q;
    logic [CNT_W-1:0]   drain_q;

    logic [OWN_W-1:0]   next_ptr;
    logic [OWN_W-1:0]   arb_base;
    logic [OWN_W-1:0]   arb_cand;
    logic [OWN_W-1:0]   arb_idx;
    logic               arb_hit;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [NUM_REQ-1:0] owner_oh;

    always_comb begin
        next_ptr = OWN_W'((int'(owner_q) + 1) % NUM_REQ);
        owner_oh = '0;
        owner_oh[owner_q] = 1'b1;
    end

    // The done cycle doubles as an arbitration slot so held requests run back-to-back,
    // searching from the pointer the finishing job is about to install.
    always_comb begin
        arb_base = (state_q == StDone) ? next_ptr : rr_q;
        arb_hit  = 1'b0;
        arb_idx  = '0;
        arb_cand = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_cand = OWN_W'((int'(arb_base) + i) % NUM_REQ);
            if (!arb_hit && bus.req[arb_cand]) begin
                arb_hit = 1'b1;
                arb_idx = arb_cand;
            end
        end
        arb_gnt = '0;
        arb_gnt[arb_idx] = arb_hit;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= StIdle;
            grant_q       <= '0;
            done_q        <= '0;
            owner_q       <= '0;
            rr_q          <= '0;
            busy_q        <= 1'b0;
            acc_clr_q     <= 1'b0;
            issue_valid_q <= 1'b0;
            row_q         <= '0;
            drain_q       <= '0;
        end else begin
            grant_q   <= '0;
            acc_clr_q <= 1'b0;
            done_q    <= '0;
            unique case (state_q)
                StIdle: begin
                    if (arb_hit) begin
                        state_q   <= StIssue;
                        grant_q   <= arb_gnt;
                        acc_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                        owner_q   <= arb_idx;
                    end
                end
                StIssue: begin
                    if (bus.abort) begin
                        state_q       <= StIdle;
                        busy_q        <= 1'b0;
                        issue_valid_q <= 1'b0;
                        row_q         <= '0;
                        rr_q          <= next_ptr;
                    end else if (!issue_valid_q) begin
                        // Grant cycle: first row strobe follows on the next cycle.
                        issue_valid_q <= 1'b1;
                    end else if (row_q == LAST_ROW) begin
                        issue_valid_q <= 1'b0;
                        row_q         <= '0;
                        drain_q       <= '0;
                        if (PIPE_LAT == 0) begin
                            state_q <= StDone;
                            done_q  <= owner_oh;
                        end else begin
                            state_q <= StDrain;
                        end
                    end else begin
                        row_q <= row_q + IDX_W'(1);
                    end
                end
                StDrain: begin
                    if (bus.abort) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        rr_q    <= next_ptr;
                    end else if (drain_q == LAST_DRAIN) begin
                        state_q <= StDone;
                        done_q  <= owner_oh;
                    end else begin
                        drain_q <= drain_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    rr_q <= next_ptr;
                    if (arb_hit) begin
                        state_q   <= StIssue;
                        grant_q   <= arb_gnt;
                        acc_clr_q <= 1'b1;
                        owner_q   <= arb_idx;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.done        = done_q;
    assign bus.owner       = owner_q;
    assign bus.busy        = busy_q;
    assign bus.acc_clr     = acc_clr_q;
    assign bus.issue_valid = issue_valid_q;
    assign bus.row_idx     = row_q;
endmodule
